pi_sweep_center_finder: RTL and testbench
=========================================

// Module: pi_sweep_center_finder
// PURPOSE
//  Phase-interpolator sweep engine for the MBTRAIN center-cal substates.
//  The center-cal TX FSM enables it. It steps the PI code across the full range and runs one point test per code.
//  It finds the widest contiguous all-lanes-pass window, parks the PI on that window's center, and acks the FSM.
//  Sits between the center-cal FSM (upstream) and the point-test block and analog PI control word (downstream).
// PARAMETERS
//  PI_W          4   PI code width; sweep covers codes 0..2^PI_W-1
//  NUM_LANES     16  data lanes in the result vector
//  SETTLE_CYCLES 4   cycles a new PI code is held before the point test starts (>=1)
// PORTS
//  clk              in   1          clock
//  rst_n            in   1          asynchronous reset, active low
//  i_en             in   1          sweep enable from the center-cal FSM; level
//  i_pt_done        in   1          point test complete, 1-cycle pulse
//  i_lanes_result   in   NUM_LANES  per-lane pass(1)/fail(0); valid with i_pt_done
//  i_lane_mask      in   NUM_LANES  1 = lane participates; 0 = ignored (forced pass)
//  o_pt_start       out  1          point test start, 1-cycle pulse
//  o_pi_step        out  PI_W       PI control word to the analog
//  o_center_code    out  PI_W       computed center code; valid while o_sweep_done=1
//  o_no_eye         out  1          no passing code found; valid while o_sweep_done=1
//  o_sweep_done     out  1          sweep finished (test ack to the FSM), level
// BEHAVIOUR
//  - Reset: all outputs 0; FSM in IDLE; code, run and best registers 0.
//  - i_en=0 in any state: next cycle FSM goes to IDLE and all outputs/registers clear to reset values.
//    The clear takes priority over every other event, including an i_pt_done in the same cycle.
//  - FSM states:
//    IDLE:   i_en=1 -> APPLY, with code=0, cur_len=0, best_len=0.
//    APPLY:  o_pi_step=code; settle counter runs SETTLE_CYCLES cycles -> TEST.
//    TEST:   o_pt_start=1 on the first TEST cycle only.
//            Then wait. i_pt_done is sampled only on cycles where o_pt_start=0.
//            On i_pt_done: latch pass and go to EVAL. No timeout; waits indefinitely.
//    EVAL:   1 cycle; update run tracking.
//            code==2^PI_W-1 -> CENTER; otherwise code++ and go to APPLY.
//    CENTER: 1 cycle; compute the result -> DONE.
//    DONE:   o_sweep_done=1 and o_pi_step=o_center_code, held while i_en=1.
//  - pass = &(i_lanes_result | ~i_lane_mask). An all-zero mask means every code passes.
//  - Run tracking (cur_len, best_len are PI_W+1 bits; max 2^PI_W):
//    pass: if cur_len==0 then cur_start=code; cur_len++.
//          If the new cur_len > best_len (strict), copy cur_start/new cur_len into best_start/best_len.
//          Ties keep the earliest window.
//    fail: cur_len=0.
//  - Center: best_start + ((best_len-1)>>1), i.e. even-length windows round toward the lower code.
//    Computed at PI_W+1 bits; the result is always <= 2^PI_W-1, so no wrap.
//  - best_len==0: o_no_eye=1, o_center_code=0, o_pi_step=0.
//  - Latency per code: SETTLE_CYCLES + 1 + (point-test time) + 1 cycles.
//  - No code wrap: the sweep stops after the last code; it never returns to 0.
//  - i_pt_done outside TEST is ignored.
//  - i_en re-asserted after DONE/IDLE starts a fresh sweep from code 0.
// TESTING
//  1 All lanes pass at every code -> best 0..15; center 7; no_eye=0; sweep_done after 16 tests.
//  2 Pass only at codes 3..9 -> o_center_code=6; o_pi_step=6 in DONE.
//  3 Pass at codes 2..4 and 8..13 -> center 10 (wider window wins).
//  4 Pass at codes 1..3 and 10..12 (tie) -> center 2 (earliest window).
//    All fail -> o_no_eye=1, center 0.
//  5 Lane 5 fails at every code but mask[5]=0; others pass at codes 4..7 -> center 5.
//    Same stimulus with mask[5]=1 -> o_no_eye=1.
//  6 i_en dropped in TEST at code 6 with i_pt_done in the same cycle -> IDLE next cycle; all outputs 0.
//    Re-enable -> o_pi_step restarts at 0.
//    Check o_pt_start is one cycle per code and exactly SETTLE_CYCLES after the code changes.

Source files
------------

// File: rtl/pi_sweep_center_finder.sv
// PI sweep engine for MBTRAIN center-cal.
// Steps the PI code over its full range and runs one point test per code.
// Tracks the widest contiguous window where all lanes pass, parks the PI on
// that window's center, and acknowledges the center-cal FSM.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for i_en; run tracking cleared on exit
// APPLY  | PI code driven, settle down-counter running
// TEST   | o_pt_start pulsed on entry, waiting for i_pt_done
// EVAL   | fold latched pass/fail into run tracking, advance code
// CENTER | derive center code / no-eye flag from the best window
// DONE   | o_sweep_done held, PI parked on the center code
module pi_sweep_center_finder #(
  parameter int PI_W          = 4,
  parameter int NUM_LANES     = 16,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_en,
  input  logic                 i_pt_done,
  input  logic [NUM_LANES-1:0] i_lanes_result,
  input  logic [NUM_LANES-1:0] i_lane_mask,
  output logic                 o_pt_start,
  output logic [PI_W-1:0]      o_pi_step,
  output logic [PI_W-1:0]      o_center_code,
  output logic                 o_no_eye,
  output logic                 o_sweep_done
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [PI_W-1:0]  CODE_MAX    = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_TEST,
    S_EVAL,
    S_CENTER,
    S_DONE
  } state_t;

  state_t           state;
  logic [PI_W-1:0]  code;
  logic [CNT_W-1:0] settle_cnt;
  logic             pass_q;
  logic [PI_W-1:0]  cur_start;
  logic [PI_W-1:0]  best_start;
  logic [PI_W:0]    cur_len;
  logic [PI_W:0]    best_len;

  logic             pass_now;
  logic [PI_W:0]    new_len;
  logic [PI_W-1:0]  new_start;
  logic [PI_W:0]    half_len;
  logic [PI_W:0]    center_sum;

  // Masked-out lanes count as passing; run extension and center arithmetic.
  always_comb begin
    pass_now   = &(i_lanes_result | ~i_lane_mask);
    new_len    = cur_len + (PI_W+1)'(1);
    new_start  = (cur_len == '0) ? code : cur_start;
    half_len   = (best_len - (PI_W+1)'(1)) >> 1;
    center_sum = (PI_W+1)'(best_start) + half_len;
  end

  // Sweep sequencer; dropping i_en clears everything ahead of any other event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      code          <= '0;
      settle_cnt    <= '0;
      pass_q        <= 1'b0;
      cur_start     <= '0;
      best_start    <= '0;
      cur_len       <= '0;
      best_len      <= '0;
      o_pt_start    <= 1'b0;
      o_pi_step     <= '0;
      o_center_code <= '0;
      o_no_eye      <= 1'b0;
      o_sweep_done  <= 1'b0;
    end else if (!i_en) begin
      state         <= S_IDLE;
      code          <= '0;
      settle_cnt    <= '0;
      pass_q        <= 1'b0;
      cur_start     <= '0;
      best_start    <= '0;
      cur_len       <= '0;
      best_len      <= '0;
      o_pt_start    <= 1'b0;
      o_pi_step     <= '0;
      o_center_code <= '0;
      o_no_eye      <= 1'b0;
      o_sweep_done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          code       <= '0;
          cur_start  <= '0;
          best_start <= '0;
          cur_len    <= '0;
          best_len   <= '0;
          o_pi_step  <= '0;
          settle_cnt <= SETTLE_LOAD;
          state      <= S_APPLY;
        end
        S_APPLY: begin
          if (settle_cnt == '0) begin
            o_pt_start <= 1'b1;
            state      <= S_TEST;
          end else begin
            settle_cnt <= settle_cnt - CNT_W'(1);
          end
        end
        S_TEST: begin
          o_pt_start <= 1'b0;
          // A done coincident with our own start pulse cannot belong to this test.
          if (!o_pt_start && i_pt_done) begin
            pass_q <= pass_now;
            state  <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (pass_q) begin
            cur_start <= new_start;
            cur_len   <= new_len;
            // Strict compare keeps the earliest of equally wide windows.
            if (new_len > best_len) begin
              best_start <= new_start;
              best_len   <= new_len;
            end
          end else begin
            cur_len <= '0;
          end
          if (code == CODE_MAX) begin
            state <= S_CENTER;
          end else begin
            code       <= code + PI_W'(1);
            o_pi_step  <= code + PI_W'(1);
            settle_cnt <= SETTLE_LOAD;
            state      <= S_APPLY;
          end
        end
        S_CENTER: begin
          if (best_len == '0) begin
            o_no_eye      <= 1'b1;
            o_center_code <= '0;
            o_pi_step     <= '0;
          end else begin
            o_no_eye      <= 1'b0;
            o_center_code <= PI_W'(center_sum);
            o_pi_step     <= PI_W'(center_sum);
          end
          o_sweep_done <= 1'b1;
          state        <= S_DONE;
        end
        S_DONE: begin
          o_sweep_done <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pi_sweep_center_finder.sv
// Randomized bench for pi_sweep_center_finder: a point-test responder feeds
// per-code lane results and a window-search model predicts the center.
module tb_pi_sweep_center_finder;

  localparam int PI_W  = 4;
  localparam int NL    = 16;
  localparam int SC    = 4;
  localparam int NCODE = 1 << PI_W;

  logic            clk;
  logic            rst_n;
  logic            i_en;
  logic            i_pt_done;
  logic [NL-1:0]   i_lanes_result;
  logic [NL-1:0]   i_lane_mask;
  logic            o_pt_start;
  logic [PI_W-1:0] o_pi_step;
  logic [PI_W-1:0] o_center_code;
  logic            o_no_eye;
  logic            o_sweep_done;

  pi_sweep_center_finder #(
    .PI_W(PI_W), .NUM_LANES(NL), .SETTLE_CYCLES(SC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_en(i_en), .i_pt_done(i_pt_done),
    .i_lanes_result(i_lanes_result), .i_lane_mask(i_lane_mask),
    .o_pt_start(o_pt_start), .o_pi_step(o_pi_step),
    .o_center_code(o_center_code), .o_no_eye(o_no_eye),
    .o_sweep_done(o_sweep_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc = 0;
  int change_cyc = 0;
  int en_cyc = 0;
  int pt_cnt = 0;
  logic [PI_W-1:0] prev_step = '0;
  logic            prev_start = 1'b0;
  logic [NL-1:0]   lanes_tab [NCODE];

  task automatic chk(input string tag, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: observed=%0d expected=%0d", tag, act, exp);
    end
  endtask

  // One clock; observe outputs on the falling edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (o_pi_step != prev_step) change_cyc = cyc;
    prev_step = o_pi_step;
    if (o_pt_start) begin
      chk("pt_start_width", int'(prev_start), 0);
      if (!prev_start) pt_cnt++;
    end
    prev_start = o_pt_start;
  endtask

  // Widest all-pass window, earliest on ties, searched longest-first.
  task automatic model(output int c, output bit ne);
    bit p [NCODE];
    c  = 0;
    ne = 1'b1;
    for (int k = 0; k < NCODE; k++)
      p[k] = ((lanes_tab[k] | ~i_lane_mask) == {NL{1'b1}});
    for (int len = NCODE; len >= 1 && ne; len--)
      for (int s = 0; s + len <= NCODE && ne; s++) begin
        bit all_ok = 1'b1;
        for (int j = s; j < s + len; j++) if (!p[j]) all_ok = 1'b0;
        if (all_ok) begin
          c  = s + (len - 1) / 2;
          ne = 1'b0;
        end
      end
  endtask

  task automatic set_pass(input logic [NCODE-1:0] v);
    i_lane_mask = '1;
    for (int k = 0; k < NCODE; k++)
      lanes_tab[k] = v[k] ? {NL{1'b1}}
                          : (NL'($urandom) & ~(NL'(1) << $urandom_range(0, NL-1)));
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_pt_start"}, int'(o_pt_start), 0);
    chk({tag, "_pi_step"}, int'(o_pi_step), 0);
    chk({tag, "_center"}, int'(o_center_code), 0);
    chk({tag, "_no_eye"}, int'(o_no_eye), 0);
    chk({tag, "_done"}, int'(o_sweep_done), 0);
  endtask

  task automatic run_sweep(input int abort_at);
    int  exp_c;
    bit  exp_ne;
    int  n;
    model(exp_c, exp_ne);
    i_en   = 1'b1;
    en_cyc = cyc;
    pt_cnt = 0;
    for (int k = 0; k < NCODE; k++) begin
      n = 0;
      while (!o_pt_start && n < 200) begin
        tick();
        n++;
      end
      if (!o_pt_start) begin
        chk("pt_start_timeout", 0, 1);
        i_en = 1'b0;
        tick();
        return;
      end
      chk("pt_code", int'(o_pi_step), k);
      chk("settle_gap", cyc - ((k == 0) ? en_cyc + 1 : change_cyc), SC);
      if (k == abort_at) begin
        tick();
        i_pt_done      = 1'b1;
        i_lanes_result = '1;
        i_en           = 1'b0;
        tick();
        i_pt_done = 1'b0;
        check_cleared("abort");
        return;
      end
      // A done overlapping the start pulse must be ignored.
      if ($urandom_range(0, 1) == 1) begin
        i_pt_done      = 1'b1;
        i_lanes_result = '0;
      end
      tick();
      i_pt_done = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
      i_pt_done      = 1'b1;
      i_lanes_result = lanes_tab[k];
      tick();
      i_pt_done      = 1'b0;
      i_lanes_result = NL'($urandom);
    end
    n = 0;
    while (!o_sweep_done && n < 20) begin
      tick();
      n++;
    end
    chk("done_latency", n, 2);
    chk("pt_count", pt_cnt, NCODE);
    chk("center", int'(o_center_code), exp_c);
    chk("no_eye", int'(o_no_eye), int'(exp_ne));
    chk("parked_step", int'(o_pi_step), exp_c);
    repeat (3) tick();
    chk("done_hold", int'(o_sweep_done), 1);
    chk("parked_hold", int'(o_pi_step), exp_c);
    i_en = 1'b0;
    tick();
    check_cleared("disable");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    i_en           = 1'b0;
    i_pt_done      = 1'b0;
    i_lanes_result = '0;
    i_lane_mask    = '1;
    repeat (2) tick();
    check_cleared("reset");
    rst_n = 1'b1;
    repeat (2) tick();
    check_cleared("idle");

    set_pass(16'hFFFF); run_sweep(-1);
    set_pass(16'h03F8); run_sweep(-1);
    set_pass(16'h3F1C); run_sweep(-1);
    set_pass(16'h1C0E); run_sweep(-1);
    set_pass(16'h0000); run_sweep(-1);

    // Lane 5 always fails; the rest pass only at codes 4..7.
    for (int k = 0; k < NCODE; k++)
      lanes_tab[k] = (k >= 4 && k <= 7) ? 16'hFFDF : 16'h0000;
    i_lane_mask = 16'hFFDF;
    run_sweep(-1);
    i_lane_mask = 16'hFFFF;
    run_sweep(-1);

    set_pass(16'hFFFF);
    run_sweep(6);
    tick();
    run_sweep(-1);

    for (int r = 0; r < 6; r++) begin
      i_lane_mask = ($urandom_range(0, 5) == 0) ? '0 : NL'($urandom);
      for (int k = 0; k < NCODE; k++)
        lanes_tab[k] = ($urandom_range(0, 9) < 7) ? {NL{1'b1}} : NL'($urandom);
      run_sweep(-1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
